// File: rtl/fe_pkg.sv
// Shared types and constants for the frontend fetch-buffer sequencer.
package fe_pkg;

   typedef enum logic [1:0] {
      RES_POP_BUF    = 2'b00,
      RES_POP_DATA   = 2'b01,
      RES_INSERT_NOP = 2'b10
   } fe_result_t;

   typedef enum logic [1:0] {
      EMPTY  = 2'b00,
      FULL   = 2'b01,
      BUBBLE = 2'b10
   } fe_state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0;
   localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_buffer_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/fetch_buffer_ctrl.sv
// One-entry instruction buffer and fetch PC sequencer feeding the frontend
// select logic; registers the selected instruction into the issue register.
//
// state  | meaning
// EMPTY  | buffer invalid; next unstalled cycle loads it from imem_data
// FULL   | buffer valid; issue per select decision every unstalled cycle
// BUBBLE | branch just issued; inject one NOP, hold buffer and fetch PC
module fetch_buffer_ctrl
   import fe_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic [31:0] imem_data,
   input  logic [31:0] sel_pc,
   input  logic [31:0] sel_instr,
   input  logic [1:0]  sel_result,
   output logic [31:0] fetch_pc,
   output logic        buf_valid,
   output logic [31:0] buf_pc,
   output logic [31:0] buf_instr,
   output logic        issue_valid,
   output logic [31:0] issue_pc,
   output logic [31:0] issue_instr,
   output logic [15:0] swap_count
);

   fe_state_t   state, state_nxt;
   logic [31:0] fetch_pc_nxt;
   logic [31:0] buf_pc_nxt, buf_instr_nxt;
   logic        issue_valid_nxt;
   logic [31:0] issue_pc_nxt, issue_instr_nxt;
   logic [31:0] pc_inc;
   logic        swap_inc;

   assign pc_inc    = fetch_pc + PC_STEP;
   assign buf_valid = (state != EMPTY);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= EMPTY;
         fetch_pc    <= RESET_PC;
         buf_pc      <= '0;
         buf_instr   <= '0;
         issue_valid <= 1'b0;
         issue_pc    <= '0;
         issue_instr <= NOP_INSTR;
      end else begin
         state       <= state_nxt;
         fetch_pc    <= fetch_pc_nxt;
         buf_pc      <= buf_pc_nxt;
         buf_instr   <= buf_instr_nxt;
         issue_valid <= issue_valid_nxt;
         issue_pc    <= issue_pc_nxt;
         issue_instr <= issue_instr_nxt;
      end
   end

   always_comb begin
      state_nxt       = state;
      fetch_pc_nxt    = fetch_pc;
      buf_pc_nxt      = buf_pc;
      buf_instr_nxt   = buf_instr;
      issue_valid_nxt = issue_valid;
      issue_pc_nxt    = issue_pc;
      issue_instr_nxt = issue_instr;
      swap_inc        = 1'b0;

      // Redirect wins over stall: the flush must land on the sampling edge.
      if (redirect) begin
         state_nxt       = EMPTY;
         fetch_pc_nxt    = {redirect_pc[31:2], 2'b00};
         issue_valid_nxt = 1'b0;
         issue_instr_nxt = NOP_INSTR;
      end else if (!stall) begin
         case (state)
            EMPTY: begin
               buf_pc_nxt      = fetch_pc;
               buf_instr_nxt   = imem_data;
               fetch_pc_nxt    = pc_inc;
               issue_valid_nxt = 1'b0;
               issue_instr_nxt = NOP_INSTR;
               state_nxt       = FULL;
            end
            FULL: begin
               issue_valid_nxt = 1'b1;
               issue_pc_nxt    = sel_pc;
               issue_instr_nxt = sel_instr;
               fetch_pc_nxt    = pc_inc;
               case (fe_result_t'(sel_result))
                  RES_POP_DATA: begin
                     swap_inc = 1'b1;
                  end
                  RES_INSERT_NOP: begin
                     buf_pc_nxt    = fetch_pc;
                     buf_instr_nxt = imem_data;
                     state_nxt     = BUBBLE;
                  end
                  default: begin
                     buf_pc_nxt    = fetch_pc;
                     buf_instr_nxt = imem_data;
                  end
               endcase
            end
            BUBBLE: begin
               issue_valid_nxt = 1'b0;
               issue_instr_nxt = NOP_INSTR;
               state_nxt       = FULL;
            end
            default: begin
               state_nxt = EMPTY;
            end
         endcase
      end
   end

   sat_counter #(
      .WIDTH (16)
   ) u_swap_cnt (
      .clk   (clk),
      .rst_n (resetn),
      .clear (1'b0),
      .inc   (swap_inc),
      .count (swap_count)
   );

endmodule

// File: tb/tb_fetch_buffer_ctrl.sv
// Self-checking bench for fetch_buffer_ctrl: directed vector table, corner
// sequences, and randomized traffic against a rule-level reference model.
module tb_fetch_buffer_ctrl;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clk;
   logic        resetn;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] imem_data;
   logic [31:0] sel_pc;
   logic [31:0] sel_instr;
   logic [1:0]  sel_result;
   logic [31:0] fetch_pc;
   logic        buf_valid;
   logic [31:0] buf_pc;
   logic [31:0] buf_instr;
   logic        issue_valid;
   logic [31:0] issue_pc;
   logic [31:0] issue_instr;
   logic [15:0] swap_count;

   int n_err = 0;
   int n_chk = 0;

   fetch_buffer_ctrl #(.RESET_PC(RST_PC)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_data   (imem_data),
      .sel_pc      (sel_pc),
      .sel_instr   (sel_instr),
      .sel_result  (sel_result),
      .fetch_pc    (fetch_pc),
      .buf_valid   (buf_valid),
      .buf_pc      (buf_pc),
      .buf_instr   (buf_instr),
      .issue_valid (issue_valid),
      .issue_pc    (issue_pc),
      .issue_instr (issue_instr),
      .swap_count  (swap_count)
   );

   function automatic logic [31:0] imem_fn(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   assign imem_data = imem_fn(fetch_pc);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: plain variables describing what the buffer holds,
   // whether a branch bubble is owed, and what decode currently sees.
   logic [31:0] m_pc;
   bit          m_has_buf;
   bit          m_bubble_owed;
   logic [31:0] m_buf_pc, m_buf_instr;
   bit          m_iv;
   logic [31:0] m_ipc, m_iinstr;
   bit          m_iinstr_known;
   int          m_swap;

   task automatic model_reset();
      m_pc           = RST_PC;
      m_has_buf      = 0;
      m_bubble_owed  = 0;
      m_buf_pc       = 0;
      m_buf_instr    = 0;
      m_iv           = 0;
      m_ipc          = 0;
      m_iinstr       = 0;
      m_iinstr_known = 1;
      m_swap         = 0;
   endtask

   task automatic model_update();
      if (redirect) begin
         m_pc           = redirect_pc & 32'hFFFF_FFFC;
         m_has_buf      = 0;
         m_bubble_owed  = 0;
         m_iv           = 0;
         m_iinstr       = 0;
         m_iinstr_known = 1;
      end else if (stall) begin
         // everything holds
      end else if (!m_has_buf) begin
         m_buf_pc       = m_pc;
         m_buf_instr    = imem_fn(m_pc);
         m_has_buf      = 1;
         m_pc           = m_pc + 4;
         m_iv           = 0;
         m_iinstr_known = 0;
      end else if (m_bubble_owed) begin
         m_bubble_owed  = 0;
         m_iv           = 0;
         m_iinstr       = 0;
         m_iinstr_known = 1;
      end else begin
         m_iv           = 1;
         m_ipc          = sel_pc;
         m_iinstr       = sel_instr;
         m_iinstr_known = 1;
         if (sel_result == 2'd1) begin
            m_swap = (m_swap >= 65535) ? 65535 : m_swap + 1;
         end else begin
            m_buf_pc    = m_pc;
            m_buf_instr = imem_fn(m_pc);
            if (sel_result == 2'd2) m_bubble_owed = 1;
         end
         m_pc = m_pc + 4;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".fetch_pc"}, fetch_pc, m_pc);
      chk({tag, ".buf_valid"}, {31'd0, buf_valid}, {31'd0, m_has_buf});
      if (m_has_buf) begin
         chk({tag, ".buf_pc"}, buf_pc, m_buf_pc);
         chk({tag, ".buf_instr"}, buf_instr, m_buf_instr);
      end
      chk({tag, ".issue_valid"}, {31'd0, issue_valid}, {31'd0, m_iv});
      if (m_iv) chk({tag, ".issue_pc"}, issue_pc, m_ipc);
      if (m_iinstr_known) chk({tag, ".issue_instr"}, issue_instr, m_iinstr);
      chk({tag, ".swap_count"}, {16'd0, swap_count}, m_swap);
   endtask

   task automatic step(input bit do_chk, input string tag);
      model_update();
      @(posedge clk);
      #1;
      if (do_chk) check_model(tag);
   endtask

   typedef struct {
      logic        stall;
      logic        redirect;
      logic [31:0] rpc;
      logic [1:0]  sel;
      logic [31:0] spc;
      logic [31:0] exp_pc;
      logic        exp_bv;
      logic [31:0] exp_bpc;
      logic        exp_iv;
      logic [31:0] exp_ipc;
      logic [15:0] exp_swap;
   } vec_t;

   vec_t vecs[10];

   initial begin
      vecs[0] = '{1'b0, 1'b0, 32'h0,   2'd0, 32'h0,   32'h104, 1'b1, 32'h100, 1'b0, 32'h0,   16'd0};
      vecs[1] = '{1'b0, 1'b0, 32'h0,   2'd0, 32'h100, 32'h108, 1'b1, 32'h104, 1'b1, 32'h100, 16'd0};
      vecs[2] = '{1'b0, 1'b0, 32'h0,   2'd1, 32'h108, 32'h10C, 1'b1, 32'h104, 1'b1, 32'h108, 16'd1};
      vecs[3] = '{1'b0, 1'b0, 32'h0,   2'd2, 32'h104, 32'h110, 1'b1, 32'h10C, 1'b1, 32'h104, 16'd1};
      vecs[4] = '{1'b0, 1'b0, 32'h0,   2'd0, 32'h0,   32'h110, 1'b1, 32'h10C, 1'b0, 32'h0,   16'd1};
      vecs[5] = '{1'b0, 1'b0, 32'h0,   2'd3, 32'h10C, 32'h114, 1'b1, 32'h110, 1'b1, 32'h10C, 16'd1};
      vecs[6] = '{1'b1, 1'b0, 32'h0,   2'd1, 32'h0,   32'h114, 1'b1, 32'h110, 1'b1, 32'h10C, 16'd1};
      vecs[7] = '{1'b1, 1'b1, 32'h403, 2'd1, 32'h0,   32'h400, 1'b0, 32'h0,   1'b0, 32'h0,   16'd1};
      vecs[8] = '{1'b0, 1'b0, 32'h0,   2'd0, 32'h0,   32'h404, 1'b1, 32'h400, 1'b0, 32'h0,   16'd1};
      vecs[9] = '{1'b0, 1'b0, 32'h0,   2'd0, 32'h400, 32'h408, 1'b1, 32'h404, 1'b1, 32'h400, 16'd1};

      resetn      = 1'b0;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      sel_pc      = '0;
      sel_instr   = '0;
      sel_result  = 2'd0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_model("reset");
      chk("reset.issue_pc", issue_pc, 32'h0);
      @(negedge clk);
      resetn = 1'b1;

      // Directed vector table
      for (int i = 0; i < 10; i++) begin
         stall       = vecs[i].stall;
         redirect    = vecs[i].redirect;
         redirect_pc = vecs[i].rpc;
         sel_result  = vecs[i].sel;
         sel_pc      = vecs[i].spc;
         sel_instr   = imem_fn(vecs[i].spc);
         step(1, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d.fetch_pc", i), fetch_pc, vecs[i].exp_pc);
         chk($sformatf("vec%0d.buf_valid", i), {31'd0, buf_valid}, {31'd0, vecs[i].exp_bv});
         if (vecs[i].exp_bv) begin
            chk($sformatf("vec%0d.buf_pc", i), buf_pc, vecs[i].exp_bpc);
            chk($sformatf("vec%0d.buf_instr", i), buf_instr, imem_fn(vecs[i].exp_bpc));
         end
         chk($sformatf("vec%0d.issue_valid", i), {31'd0, issue_valid}, {31'd0, vecs[i].exp_iv});
         if (vecs[i].exp_iv) begin
            chk($sformatf("vec%0d.issue_pc", i), issue_pc, vecs[i].exp_ipc);
            chk($sformatf("vec%0d.issue_instr", i), issue_instr, imem_fn(vecs[i].exp_ipc));
         end
         chk($sformatf("vec%0d.swap_count", i), {16'd0, swap_count}, {16'd0, vecs[i].exp_swap});
      end
      stall    = 1'b0;
      redirect = 1'b0;

      // Swap counter saturation
      sel_result = 2'd1;
      for (int i = 0; i < 70000; i++) begin
         sel_pc    = $urandom;
         sel_instr = $urandom;
         step(0, "swap");
      end
      check_model("swap_sat");
      chk("swap_sat.value", {16'd0, swap_count}, 32'h0000_FFFF);

      // Three stalled cycles in FULL: nothing moves
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sel_result = 2'($urandom_range(0, 3));
         sel_pc     = $urandom;
         sel_instr  = $urandom;
         step(1, $sformatf("stall%0d", i));
      end
      stall = 1'b0;

      // Fetch PC wrap at the top of the address space
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFB;
      step(1, "wrap_redir");
      chk("wrap_redir.fetch_pc", fetch_pc, 32'hFFFF_FFF8);
      redirect   = 1'b0;
      sel_result = 2'd0;
      step(1, "wrap_fill");
      sel_pc    = 32'hFFFF_FFF8;
      sel_instr = imem_fn(32'hFFFF_FFF8);
      step(1, "wrap_pop");
      chk("wrap_pop.fetch_pc", fetch_pc, 32'h0);
      chk("wrap_pop.buf_pc", buf_pc, 32'hFFFF_FFFC);

      // Async reset mid-run: outputs clear before any clock edge
      #2;
      resetn = 1'b0;
      #1;
      model_reset();
      check_model("async_rst");
      chk("async_rst.issue_pc", issue_pc, 32'h0);
      chk("async_rst.buf_pc", buf_pc, 32'h0);
      @(negedge clk);
      resetn = 1'b1;

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         stall       = ($urandom_range(0, 3) == 0);
         redirect    = ($urandom_range(0, 19) == 0);
         redirect_pc = $urandom;
         sel_result  = 2'($urandom_range(0, 3));
         sel_pc      = $urandom;
         sel_instr   = $urandom;
         step(1, "rand");
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
